// File: rtl/trng_ctrl.sv
// Sequencing controller for a ring-oscillator TRNG: warm-up, pipeline flush, word assembly, RCT health test.
// Latency: a word is offered one cycle after the take strobe that supplies its last bit.
// Backpressure: a held word stops sampling (no dff_en pulses) until valid_o && ready_i.
module trng_ctrl #(
  parameter int WORD_WIDTH    = 32,
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 4,
  parameter int PIPE_FLUSH    = 2,
  parameter int RCT_CUTOFF    = 32
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_fail_i,
  input  logic                  random_bit_i,
  output logic                  ro_en_o,
  output logic                  dff_en_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  fail_o
);

  localparam int WU_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int FL_W  = (PIPE_FLUSH > 1) ? $clog2(PIPE_FLUSH) : 1;
  localparam int BC_W  = $clog2(WORD_WIDTH);
  localparam int RC_W  = $clog2(RCT_CUTOFF + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    FLUSH   = 3'd2,
    COLLECT = 3'd3,
    HOLD    = 3'd4,
    FAIL    = 3'd5
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [WU_W-1:0]         warm_cnt;
  logic [DIV_W-1:0]        div_cnt;
  logic [FL_W-1:0]         flush_cnt;
  logic [BC_W-1:0]         bit_cnt;
  logic [RC_W-1:0]         rct_cnt;
  logic [RC_W-1:0]         rct_nxt;
  logic                    last_bit;
  logic                    first_take;
  logic [WORD_WIDTH-1:0]   shreg;
  logic [WORD_WIDTH-1:0]   shift_nxt;
  logic [WORD_WIDTH-1:0]   word;
  logic                    valid;
  logic                    dff_en;
  logic                    take;
  logic                    run;
  logic                    run_nxt;

  // Sampling is live only while staying inside FLUSH/COLLECT; any exit or entry restarts the divider.
  assign run     = (state == FLUSH) || (state == COLLECT);
  assign run_nxt = (state_nxt == FLUSH) || (state_nxt == COLLECT);

  // The first accepted bit after a flush starts a fresh repetition run.
  assign rct_nxt   = (first_take || (random_bit_i != last_bit)) ? RC_W'(1) : rct_cnt + RC_W'(1);
  assign shift_nxt = {shreg[WORD_WIDTH-2:0], random_bit_i};

  assign dff_en_o = dff_en;
  assign word_o   = word;
  assign valid_o  = valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs; a take strobe with start_i low is ignored.
  always_comb begin
    state_nxt = state;
    ro_en_o   = 1'b0;
    busy_o    = 1'b0;
    fail_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = WARMUP;
      end
      WARMUP: begin
        ro_en_o = 1'b1;
        busy_o  = 1'b1;
        if (!start_i) state_nxt = IDLE;
        else if (warm_cnt == WU_W'(WARMUP_CYCLES - 1))
          state_nxt = (PIPE_FLUSH == 0) ? COLLECT : FLUSH;
      end
      FLUSH: begin
        ro_en_o = 1'b1;
        busy_o  = 1'b1;
        if (!start_i) state_nxt = IDLE;
        else if (take && (flush_cnt == FL_W'(PIPE_FLUSH - 1))) state_nxt = COLLECT;
      end
      COLLECT: begin
        ro_en_o = 1'b1;
        busy_o  = 1'b1;
        if (!start_i) state_nxt = IDLE;
        else if (take) begin
          // A health failure beats word completion on the same strobe.
          if (rct_nxt >= RC_W'(RCT_CUTOFF))            state_nxt = FAIL;
          else if (bit_cnt == BC_W'(WORD_WIDTH - 1))   state_nxt = HOLD;
        end
      end
      HOLD: begin
        ro_en_o = 1'b1;
        busy_o  = 1'b1;
        if (valid && ready_i) state_nxt = start_i ? COLLECT : IDLE;
      end
      FAIL: begin
        fail_o = 1'b1;
        if (clear_fail_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, sample strobes, shift register, health-test state and the output word.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      warm_cnt   <= '0;
      div_cnt    <= '0;
      flush_cnt  <= '0;
      bit_cnt    <= '0;
      rct_cnt    <= '0;
      last_bit   <= 1'b0;
      first_take <= 1'b0;
      shreg      <= '0;
      word       <= '0;
      valid      <= 1'b0;
      dff_en     <= 1'b0;
      take       <= 1'b0;
    end else begin
      // Core output register updates on the pulse edge, so the bit is taken one cycle later.
      dff_en <= run && run_nxt && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
      take   <= dff_en;

      warm_cnt <= (state == WARMUP) ? warm_cnt + WU_W'(1) : '0;

      if (run && run_nxt)
        div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      else
        div_cnt <= '0;

      if (state != FLUSH) flush_cnt <= '0;
      else if (take)      flush_cnt <= flush_cnt + FL_W'(1);

      if ((state_nxt == COLLECT) && ((state == WARMUP) || (state == FLUSH)))
        first_take <= 1'b1;
      else if ((state == COLLECT) && take)
        first_take <= 1'b0;

      // Partial words and health history are dropped whenever the generator is stopped or failed.
      if ((state == COLLECT) && take && start_i) begin
        shreg    <= shift_nxt;
        last_bit <= random_bit_i;
        rct_cnt  <= rct_nxt;
        bit_cnt  <= (bit_cnt == BC_W'(WORD_WIDTH - 1)) ? '0 : bit_cnt + BC_W'(1);
      end else if ((state == IDLE) || (state == FAIL)) begin
        shreg    <= '0;
        last_bit <= 1'b0;
        rct_cnt  <= '0;
        bit_cnt  <= '0;
      end

      if (state_nxt == FAIL) begin
        word  <= '0;
        valid <= 1'b0;
      end else if ((state == COLLECT) && (state_nxt == HOLD)) begin
        word  <= shift_nxt;
        valid <= 1'b1;
      end else if ((state == HOLD) && ready_i) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl with a scoreboard of expected words and a simple TRNG core model.
// Core model: each dff_en_o pulse advances the core output (alternating from 1, or stuck at 1).
// Words are checked by a monitor at each valid/ready handshake; timing is checked by the main sequence.
module tb_trng_ctrl;

  localparam int WW = 8;
  localparam int WU = 8;
  localparam int SD = 4;
  localparam int PF = 2;
  localparam int RC = 5;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          clear_fail_i;
  logic          random_bit_i;
  logic          ro_en_o;
  logic          dff_en_o;
  logic [WW-1:0] word_o;
  logic          valid_o;
  logic          ready_i;
  logic          busy_o;
  logic          fail_o;

  int            n_total = 0;
  int            n_pass  = 0;
  logic [WW-1:0] exp_q[$];
  int            core_mode  = 0;
  int            core_epoch = 0;

  trng_ctrl #(
    .WORD_WIDTH   (WW),
    .WARMUP_CYCLES(WU),
    .SAMPLE_DIV   (SD),
    .PIPE_FLUSH   (PF),
    .RCT_CUTOFF   (RC)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .clear_fail_i(clear_fail_i),
    .random_bit_i(random_bit_i),
    .ro_en_o     (ro_en_o),
    .dff_en_o    (dff_en_o),
    .word_o      (word_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .fail_o      (fail_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // which: 0 ro_en, 1 dff_en, 2 valid, 3 fail, 4 handshake. n = negedges waited (first = 1).
  task automatic wait_sig(input int which, input int bound, input string name, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = ro_en_o;
        1:       hit = dff_en_o;
        2:       hit = valid_o;
        3:       hit = fail_o;
        4:       hit = valid_o && ready_i;
        default: hit = 1'b0;
      endcase
    end
    if (!hit) begin
      n_total++;
      $display("FAIL %s: no event within %0d cycles", name, bound);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ro_en"},  ro_en_o,  0);
    chk({tag, "_dff_en"}, dff_en_o, 0);
    chk({tag, "_valid"},  valid_o,  0);
    chk({tag, "_word"},   word_o,   0);
    chk({tag, "_busy"},   busy_o,   0);
    chk({tag, "_fail"},   fail_o,   0);
  endtask

  // TRNG core model: output register advances on the edge where dff_en_o is high.
  initial begin : core_model
    logic pend;
    logic b;
    int   seen;
    random_bit_i = 1'b0;
    b    = 1'b0;
    seen = 0;
    forever begin
      @(negedge clk);
      pend = dff_en_o;
      @(posedge clk);
      #1;
      if (seen != core_epoch) begin
        seen = core_epoch;
        b    = 1'b0;
      end
      if (pend) b = (core_mode == 1) ? 1'b1 : ~b;
      random_bit_i = b;
    end
  end

  // Scoreboard monitor: every accepted word must match the next expected word.
  initial begin : monitor
    logic [WW-1:0] e;
    forever begin
      @(negedge clk);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word: got 0x%0h, required no word", word_o);
        end else begin
          e = exp_q.pop_front();
          chk("word", word_o, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin : main
    int   n;
    logic [WW-1:0] w0;
    logic ok_stable;
    logic ok_dff;

    rst_i = 1'b1; start_i = 1'b0; clear_fail_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; rst_i = 1'b0;

    // Warm-up and flush timing, then two back-to-back 0xAA words.
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAA);
    @(posedge clk); #1; core_mode = 0; core_epoch++; start_i = 1'b1;
    wait_sig(0, 10, "ro_en_rise", n);
    chk("ro_en_rise_delay", n, 2);
    chk("busy_in_warmup", busy_o, 1);
    wait_sig(1, 100, "first_pulse", n);
    chk("first_pulse_delay", n, WU + SD);
    wait_sig(4, 200, "first_word", n);
    chk("first_word_delay", n, SD * (PF + WW - 1) + 2);
    @(negedge clk);
    chk("valid_one_cycle", valid_o, 0);
    wait_sig(4, 200, "second_word", n);
    chk("second_word_delay", n, SD * WW + 2);

    // Backpressure: word held stable, no sampling, resume SD edges after the handshake edge.
    exp_q.push_back(8'hAA);
    @(posedge clk); #1; ready_i = 1'b0;
    wait_sig(2, 200, "third_word", n);
    w0 = word_o;
    ok_stable = 1'b1;
    ok_dff    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!valid_o || word_o !== w0) ok_stable = 1'b0;
      if (dff_en_o) ok_dff = 1'b0;
    end
    chk("held_word_value", w0, 8'hAA);
    chk("held_word_stable", ok_stable, 1);
    chk("held_no_dff_en", ok_dff, 1);
    @(posedge clk); #1; ready_i = 1'b1;
    wait_sig(4, 10, "handshake_on_ready", n);
    chk("handshake_delay", n, 1);
    wait_sig(1, 20, "pulse_after_hs", n);
    chk("pulse_after_hs_delay", n, SD + 1);

    // Drop start after the third bit of the next word; restart needs full warm-up and flush.
    wait_sig(1, 20, "pulse2", n);
    wait_sig(1, 20, "pulse3", n);
    @(posedge clk);
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stop_ro_en", ro_en_o, 0);
    chk("stop_busy", busy_o, 0);
    chk("stop_valid", valid_o, 0);
    exp_q.push_back(8'hAA);
    @(posedge clk); #1; core_epoch++; start_i = 1'b1;
    wait_sig(0, 10, "restart_ro_en", n);
    chk("restart_ro_en_delay", n, 2);
    wait_sig(1, 100, "restart_pulse", n);
    chk("restart_pulse_delay", n, WU + SD);
    wait_sig(4, 200, "restart_word", n);
    chk("restart_word_delay", n, SD * (PF + WW - 1) + 2);

    // Stuck-at-1 bits: failure after RC accepted bits, no word, then clear.
    @(posedge clk); #1; start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; core_mode = 1; core_epoch++; start_i = 1'b1;
    wait_sig(0, 10, "stuck_ro_en", n);
    wait_sig(3, 200, "health_fail", n);
    chk("health_fail_delay", n, WU + SD * (PF + RC) + 2);
    chk("fail_ro_en", ro_en_o, 0);
    chk("fail_busy", busy_o, 0);
    chk("fail_valid", valid_o, 0);
    chk("fail_word", word_o, 0);
    repeat (3) @(negedge clk);
    chk("fail_latched", fail_o, 1);
    @(posedge clk); #1; clear_fail_i = 1'b1;
    @(posedge clk); #1; clear_fail_i = 1'b0;
    @(negedge clk);
    chk("cleared_fail", fail_o, 0);
    chk("cleared_idle_ro_en", ro_en_o, 0);
    @(negedge clk);
    chk("rewarm_ro_en", ro_en_o, 1);
    @(posedge clk); #1; start_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while a word is held.
    #1; core_mode = 0; core_epoch++; ready_i = 1'b0; start_i = 1'b1;
    wait_sig(2, 200, "word_before_reset", n);
    chk("word_before_reset", word_o, 8'hAA);
    @(posedge clk); #1; rst_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    chk("valid_before_reset_edge", valid_o, 1);
    @(negedge clk);
    chk_all_zero("hold_reset");
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
